// File: rtl/ycr_idle_mon_pkg.sv
// rtl/ycr_idle_mon_pkg.sv - shared types and defaults for the destination idle monitor
package ycr_idle_mon_pkg;

    typedef enum logic [1:0] {
        ST_BUSY   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_IDLE   = 2'b10
    } idle_st_e;

    localparam int IDLE_MON_CNT_W = 4;
    localparam int IDLE_MON_DLY_W = 4;

    // Quiet means nothing in flight, nothing being presented, no external busy source.
    function automatic logic mon_quiet(
        input logic cnt_zero,
        input logic req_vld,
        input logic rsp_vld,
        input logic busy_ext
    );
        return cnt_zero & ~req_vld & ~rsp_vld & ~busy_ext;
    endfunction

endpackage

// File: rtl/ycr_idle_outst_cnt.sv
// rtl/ycr_idle_outst_cnt.sv - saturating outstanding-transaction counter with sticky ovf/unf flags
module ycr_idle_outst_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             err_clr,
    output logic [CNT_W-1:0] count,
    output logic             err_ovf,
    output logic             err_unf
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic inc_only;
    logic dec_only;
    logic ovf_evt;
    logic unf_evt;

    // Simultaneous inc and dec cancel, so they can never fault at either rail.
    assign inc_only = inc & ~dec;
    assign dec_only = dec & ~inc;
    assign ovf_evt  = inc_only & (count == CNT_MAX);
    assign unf_evt  = dec_only & (count == CNT_ZERO);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc_only && !ovf_evt) begin
            count <= count + CNT_W'(1);
        end else if (dec_only && !unf_evt) begin
            count <= count - CNT_W'(1);
        end
    end

    // A fresh error in the clearing cycle wins over the clear.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            err_ovf <= ovf_evt | (err_ovf & ~err_clr);
            err_unf <= unf_evt | (err_unf & ~err_clr);
        end
    end

endmodule

// File: rtl/ycr_dst_idle_mon.sv
// rtl/ycr_dst_idle_mon.sv - destination idle monitor with settle filter; optional stats via YCR_IDLE_MON_STATS_EN
module ycr_dst_idle_mon
    import ycr_idle_mon_pkg::*;
#(
    parameter int CNT_W = IDLE_MON_CNT_W,
    parameter int DLY_W = IDLE_MON_DLY_W
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [DLY_W-1:0] cfg_idle_dly,
    input  logic             req_vld,
    input  logic             req_ack,
    input  logic             rsp_vld,
    input  logic             rsp_ack,
    input  logic             dst_busy_ext,
    input  logic             err_clr,
`ifdef YCR_IDLE_MON_STATS_EN
    input  logic             stat_clr,
    output logic [31:0]      idle_cycles,
`endif
    output logic             dst_idle,
    output logic [CNT_W-1:0] outstanding,
    output logic             err_ovf,
    output logic             err_unf
);

    idle_st_e         state_q;
    idle_st_e         state_nxt;
    logic [DLY_W-1:0] timer_q;
    logic [DLY_W-1:0] timer_nxt;
    logic             dst_idle_nxt;
    logic             quiet;

    ycr_idle_outst_cnt #(
        .CNT_W (CNT_W)
    ) u_outst_cnt (
        .clk_in  (clk_in),
        .reset   (reset),
        .inc     (req_vld & req_ack),
        .dec     (rsp_vld & rsp_ack),
        .err_clr (err_clr),
        .count   (outstanding),
        .err_ovf (err_ovf),
        .err_unf (err_unf)
    );

    assign quiet = mon_quiet((outstanding == '0), req_vld, rsp_vld, dst_busy_ext);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q  <= ST_BUSY;
            timer_q  <= '0;
            dst_idle <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            timer_q  <= timer_nxt;
            dst_idle <= dst_idle_nxt;
        end
    end

    // The delay is captured only on SETTLE entry; later cfg changes wait for the next entry.
    always_comb begin
        state_nxt = state_q;
        timer_nxt = timer_q;
        case (state_q)
            ST_BUSY: begin
                if (quiet) begin
                    state_nxt = ST_SETTLE;
                    timer_nxt = cfg_idle_dly;
                end
            end
            ST_SETTLE: begin
                if (!quiet) begin
                    state_nxt = ST_BUSY;
                end else if (timer_q == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    timer_nxt = timer_q - DLY_W'(1);
                end
            end
            ST_IDLE: begin
                if (!quiet) begin
                    state_nxt = ST_BUSY;
                end
            end
            default: begin
                state_nxt = ST_BUSY;
            end
        endcase
    end

    // Registered from the next state so dst_idle tracks IDLE with no input-to-output path.
    always_comb begin
        dst_idle_nxt = 1'b0;
        if (state_nxt == ST_IDLE) begin
            dst_idle_nxt = 1'b1;
        end
    end

`ifdef YCR_IDLE_MON_STATS_EN
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            idle_cycles <= '0;
        end else if (stat_clr) begin
            idle_cycles <= '0;
        end else if ((state_q == ST_IDLE) && (idle_cycles != 32'hFFFF_FFFF)) begin
            idle_cycles <= idle_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ycr_dst_idle_mon.sv
// tb/tb_ycr_dst_idle_mon.sv - self-checking bench for ycr_dst_idle_mon
module tb_ycr_dst_idle_mon;

    logic       clk;
    logic       reset;
    logic [3:0] cfg_idle_dly;
    logic       req_vld, req_ack, rsp_vld, rsp_ack, dst_busy_ext, err_clr;
    logic       dst_idle, err_ovf, err_unf;
    logic [3:0] outstanding;
    logic       dst_idle2, err_ovf2, err_unf2;
    logic [1:0] outstanding2;
`ifdef YCR_IDLE_MON_STATS_EN
    logic        stat_clr;
    logic [31:0] idle_cycles;
    logic [31:0] idle_cycles2;
    logic [31:0] m_ic;
`endif

    int checks = 0;
    int failures = 0;

    ycr_dst_idle_mon #(.CNT_W(4), .DLY_W(4)) dut (
        .clk_in(clk), .reset(reset), .cfg_idle_dly(cfg_idle_dly),
        .req_vld(req_vld), .req_ack(req_ack), .rsp_vld(rsp_vld), .rsp_ack(rsp_ack),
        .dst_busy_ext(dst_busy_ext), .err_clr(err_clr),
`ifdef YCR_IDLE_MON_STATS_EN
        .stat_clr(stat_clr), .idle_cycles(idle_cycles),
`endif
        .dst_idle(dst_idle), .outstanding(outstanding), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    ycr_dst_idle_mon #(.CNT_W(2), .DLY_W(4)) dut2 (
        .clk_in(clk), .reset(reset), .cfg_idle_dly(cfg_idle_dly),
        .req_vld(req_vld), .req_ack(req_ack), .rsp_vld(rsp_vld), .rsp_ack(rsp_ack),
        .dst_busy_ext(dst_busy_ext), .err_clr(err_clr),
`ifdef YCR_IDLE_MON_STATS_EN
        .stat_clr(stat_clr), .idle_cycles(idle_cycles2),
`endif
        .dst_idle(dst_idle2), .outstanding(outstanding2), .err_ovf(err_ovf2), .err_unf(err_unf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: idle after a run of D+2 quiet edges, D taken at the run's first edge.
    int   m_cnt  [2];
    bit   m_ovf  [2];
    bit   m_unf  [2];
    int   m_run  [2];
    int   m_dent [2];
    bit   m_idle [2];
    int   m_max  [2] = '{15, 3};

    always @(posedge clk or posedge reset) begin
        int  c, r, d;
        bit  q, inc, dec, ov, un;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] <= 0; m_ovf[k] <= 0; m_unf[k] <= 0;
                m_run[k] <= 0; m_dent[k] <= 0; m_idle[k] <= 0;
            end
`ifdef YCR_IDLE_MON_STATS_EN
            m_ic <= 0;
`endif
        end else begin
`ifdef YCR_IDLE_MON_STATS_EN
            if (stat_clr) m_ic <= 0;
            else if (m_idle[0] && m_ic != 32'hFFFF_FFFF) m_ic <= m_ic + 1;
`endif
            inc = req_vld && req_ack;
            dec = rsp_vld && rsp_ack;
            for (int k = 0; k < 2; k++) begin
                c = m_cnt[k];
                q = (c == 0) && !req_vld && !rsp_vld && !dst_busy_ext;
                r = m_run[k];
                d = m_dent[k];
                if (q) begin
                    if (r == 0) d = int'(cfg_idle_dly);
                    if (r < 1000) r = r + 1;
                end else begin
                    r = 0;
                end
                m_run[k]  <= r;
                m_dent[k] <= d;
                m_idle[k] <= q && (r >= d + 2);
                ov = inc && !dec && (c == m_max[k]);
                un = dec && !inc && (c == 0);
                if (inc && !dec && !ov) c = c + 1;
                if (dec && !inc && !un) c = c - 1;
                m_cnt[k] <= c;
                m_ovf[k] <= ov || (m_ovf[k] && !err_clr);
                m_unf[k] <= un || (m_unf[k] && !err_clr);
            end
        end
    end

    always @(negedge clk) begin
        chk("mdl_cnt4", 32'(outstanding), m_cnt[0]);
        chk("mdl_idle4", 32'(dst_idle), 32'(m_idle[0]));
        chk("mdl_ovf4", 32'(err_ovf), 32'(m_ovf[0]));
        chk("mdl_unf4", 32'(err_unf), 32'(m_unf[0]));
        chk("mdl_cnt2", 32'(outstanding2), m_cnt[1]);
        chk("mdl_idle2", 32'(dst_idle2), 32'(m_idle[1]));
        chk("mdl_ovf2", 32'(err_ovf2), 32'(m_ovf[1]));
        chk("mdl_unf2", 32'(err_unf2), 32'(m_unf[1]));
`ifdef YCR_IDLE_MON_STATS_EN
        chk("mdl_stats", idle_cycles, m_ic);
`endif
    end

    task automatic set_in(input logic rv, input logic ra, input logic pv, input logic pa,
                          input logic bz, input logic ec);
        req_vld = rv; req_ack = ra; rsp_vld = pv; rsp_ack = pa; dst_busy_ext = bz; err_clr = ec;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] d);
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        cfg_idle_dly = d;
`ifdef YCR_IDLE_MON_STATS_EN
        stat_clr = 1'b0;
`endif
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    typedef struct {
        logic rv, ra, pv, pa, bz, ec;
        logic [3:0] exp_cnt;
        logic       exp_idle, exp_ovf, exp_unf;
    } vec_t;

    vec_t vecs[14];

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        cfg_idle_dly = 4'd0;
`ifdef YCR_IDLE_MON_STATS_EN
        stat_clr = 1'b0;
`endif
        vecs[0]  = '{1,1,0,0,0,0, 4'd1, 0,0,0};
        vecs[1]  = '{1,1,0,0,0,0, 4'd2, 0,0,0};
        vecs[2]  = '{1,1,0,0,0,0, 4'd3, 0,0,0};
        vecs[3]  = '{0,0,1,1,0,0, 4'd2, 0,0,0};
        vecs[4]  = '{0,0,1,1,0,0, 4'd1, 0,0,0};
        vecs[5]  = '{0,0,1,1,0,0, 4'd0, 0,0,0};
        vecs[6]  = '{0,0,0,0,0,0, 4'd0, 0,0,0};
        vecs[7]  = '{0,0,0,0,0,0, 4'd0, 1,0,0};
        vecs[8]  = '{1,0,0,0,0,0, 4'd0, 0,0,0};
        vecs[9]  = '{1,1,1,1,0,0, 4'd0, 0,0,0};
        vecs[10] = '{0,0,1,1,0,0, 4'd0, 0,0,1};
        vecs[11] = '{0,0,0,0,0,1, 4'd0, 0,0,0};
        vecs[12] = '{0,0,1,1,0,1, 4'd0, 0,0,1};
        vecs[13] = '{0,0,0,0,0,1, 4'd0, 0,0,0};

        // Reset state, then D=3 latency from reset.
        do_reset(4'd3);
        chk("rst_idle", 32'(dst_idle), 0);
        chk("rst_cnt", 32'(outstanding), 0);
        chk("rst_err", 32'({err_ovf, err_unf}), 0);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk($sformatf("d3_idle_e%0d", i), 32'(dst_idle), (i == 5) ? 1 : 0);
        end

        // Table: counting, idle with D=0, same-cycle inc/dec, underflow, clear priority.
        do_reset(4'd0);
        for (int i = 0; i < 14; i++) begin
            set_in(vecs[i].rv, vecs[i].ra, vecs[i].pv, vecs[i].pa, vecs[i].bz, vecs[i].ec);
            cyc();
            chk($sformatf("vec%0d_cnt", i), 32'(outstanding), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_idle", i), 32'(dst_idle), 32'(vecs[i].exp_idle));
            chk($sformatf("vec%0d_ovf", i), 32'(err_ovf), 32'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_unf", i), 32'(err_unf), 32'(vecs[i].exp_unf));
        end

        // Overflow on the 2-bit instance, then clear.
        do_reset(4'd0);
        for (int i = 1; i <= 4; i++) begin
            set_in(1, 1, 0, 0, 0, 0);
            cyc();
            chk($sformatf("ovf_cnt_%0d", i), 32'(outstanding2), (i > 3) ? 3 : i);
        end
        chk("ovf_set", 32'(err_ovf2), 1);
        chk("ovf_wide_cnt", 32'(outstanding), 4);
        set_in(0, 0, 0, 0, 0, 1);
        cyc();
        chk("ovf_clr", 32'(err_ovf2), 0);
        chk("ovf_clr_cnt", 32'(outstanding2), 3);
        set_in(0, 0, 0, 0, 0, 0);

        // Settle abandoned by a busy pulse: full D+2 quiet run needed afterwards.
        do_reset(4'd5);
        repeat (4) cyc();
        dst_busy_ext = 1'b1;
        cyc();
        chk("abort_idle", 32'(dst_idle), 0);
        dst_busy_ext = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            cyc();
            chk($sformatf("abort_run_e%0d", i), 32'(dst_idle), (i == 7) ? 1 : 0);
        end

        // Async reset while idle with a sticky error pending.
        do_reset(4'd0);
        set_in(0, 0, 1, 1, 0, 0);
        cyc();
        set_in(0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        chk("pre_arst_idle", 32'(dst_idle), 1);
        chk("pre_arst_unf", 32'(err_unf), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_idle", 32'(dst_idle), 0);
        chk("arst_unf", 32'(err_unf), 0);
        chk("arst_cnt", 32'(outstanding), 0);
        cyc();
        reset = 1'b0;

`ifdef YCR_IDLE_MON_STATS_EN
        do_reset(4'd0);
        cyc();
        cyc();
        repeat (10) cyc();
        chk("stats_10", idle_cycles, 10);
        stat_clr = 1'b1;
        cyc();
        stat_clr = 1'b0;
        chk("stats_clr", idle_cycles, 0);
`endif

        // Randomized traffic with alternating drain phases so quiet runs occur.
        do_reset(4'd2);
        for (int i = 0; i < 3000; i++) begin
            if (((i / 40) % 2) == 1) begin
                set_in(0, 0, ($urandom_range(0, 99) < 50), 1'b1,
                       ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 5));
            end else begin
                set_in(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 70),
                       ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 70),
                       ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 5));
            end
            if ($urandom_range(0, 99) < 10) cfg_idle_dly = 4'($urandom_range(0, 15));
`ifdef YCR_IDLE_MON_STATS_EN
            stat_clr = ($urandom_range(0, 99) < 2);
`endif
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
